// File: rtl/mesh_task_ctrl_pkg.sv
// Shared widths, FSM encoding and per-PE config record for the mesh run controller.
package mesh_task_ctrl_pkg;

  localparam int N_PE         = 8;
  localparam int IDX_W        = 3;
  localparam int NUM_W        = 16;
  localparam int RATE_W       = 8;
  localparam int DST_W        = 8;
  localparam int MODE_W       = 2;
  localparam int LAT_W        = 16;
  localparam int SUM_W        = 32;
  localparam int FLUSH_CYCLES = 4;
  localparam int FCNT_W       = $clog2(FLUSH_CYCLES);
  localparam int TO_W         = 24;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_RUN,
    ST_COLLECT,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic              dbg;
    logic [NUM_W-1:0]  send_num;
    logic [NUM_W-1:0]  receive_num;
    logic [RATE_W-1:0] rate;
    logic [DST_W-1:0]  dst_seq;
    logic [MODE_W-1:0] mode;
  } pe_cfg_t;

  function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] a,
                                               input logic [SUM_W-1:0] b);
    logic [SUM_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[SUM_W] ? '1 : s[SUM_W-1:0];
  endfunction

endpackage

// File: rtl/mesh_task_ctrl_if.sv
// Controller <-> mesh bus: per-PE config/enable/flush out, completion flags and latency stats in.
interface mesh_task_ctrl_if;
  import mesh_task_ctrl_pkg::*;

  // No valid/ready here: the controller drives config levels continuously, the mesh
  // returns done flags that are sampled every RUN cycle and latched sticky, and the
  // latency vectors are read one PE per cycle while the controller is in COLLECT.
  logic [N_PE-1:0]        pe_enable;
  logic [N_PE-1:0]        pe_flush;
  logic [N_PE-1:0]        pe_dbg_mode;
  logic [N_PE*NUM_W-1:0]  pe_send_num;
  logic [N_PE*NUM_W-1:0]  pe_receive_num;
  logic [N_PE*RATE_W-1:0] pe_rate;
  logic [N_PE*DST_W-1:0]  pe_dst_seq;
  logic [N_PE*MODE_W-1:0] pe_mode;
  logic [N_PE-1:0]        pe_send_done;
  logic [N_PE-1:0]        pe_recv_done;
  logic [N_PE*LAT_W-1:0]  pe_lat_min;
  logic [N_PE*LAT_W-1:0]  pe_lat_max;
  logic [N_PE*SUM_W-1:0]  pe_lat_sum;

  modport master (
    output pe_enable, pe_flush, pe_dbg_mode, pe_send_num, pe_receive_num,
           pe_rate, pe_dst_seq, pe_mode,
    input  pe_send_done, pe_recv_done, pe_lat_min, pe_lat_max, pe_lat_sum
  );

  modport slave (
    input  pe_enable, pe_flush, pe_dbg_mode, pe_send_num, pe_receive_num,
           pe_rate, pe_dst_seq, pe_mode,
    output pe_send_done, pe_recv_done, pe_lat_min, pe_lat_max, pe_lat_sum
  );

endinterface

// File: rtl/mesh_lat_agg.sv
// Aggregate latency accumulator: running min/max and saturating sum over the PEs fed in.
module mesh_lat_agg
  import mesh_task_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             valid,
  input  logic [LAT_W-1:0] in_min,
  input  logic [LAT_W-1:0] in_max,
  input  logic [SUM_W-1:0] in_sum,
  output logic [LAT_W-1:0] agg_min,
  output logic [LAT_W-1:0] agg_max,
  output logic [SUM_W-1:0] agg_sum
);

  logic [LAT_W-1:0] min_q, min_d;
  logic [LAT_W-1:0] max_q, max_d;
  logic [SUM_W-1:0] sum_q, sum_d;

  always_comb begin
    min_d = min_q;
    max_d = max_q;
    sum_d = sum_q;
    if (clear) begin
      min_d = '1;
      max_d = '0;
      sum_d = '0;
    end else if (valid) begin
      if (in_min < min_q) min_d = in_min;
      if (in_max > max_q) max_d = in_max;
      sum_d = sat_add(sum_q, in_sum);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min_q <= '1;
      max_q <= '0;
      sum_q <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
      sum_q <= sum_d;
    end
  end

  assign agg_min = min_q;
  assign agg_max = max_q;
  assign agg_sum = sum_q;

endmodule

// File: rtl/mesh_task_ctrl.sv
// Mesh traffic run controller: holds PE task config, flushes, runs until done/timeout,
// then scans per-PE latency stats into aggregate min/max/sum.
module mesh_task_ctrl
  import mesh_task_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_addr,
  input  logic              cfg_dbg,
  input  logic [NUM_W-1:0]  cfg_send_num,
  input  logic [NUM_W-1:0]  cfg_receive_num,
  input  logic [RATE_W-1:0] cfg_rate,
  input  logic [DST_W-1:0]  cfg_dst_seq,
  input  logic [MODE_W-1:0] cfg_mode,
  input  logic [TO_W-1:0]   timeout_cycles,
  mesh_task_ctrl_if.master  pe,
  output logic              busy,
  output logic              done,
  output logic              timed_out,
  output logic [TO_W-1:0]   run_cycles,
  output logic [LAT_W-1:0]  agg_lat_min,
  output logic [LAT_W-1:0]  agg_lat_max,
  output logic [SUM_W-1:0]  agg_lat_sum,
  output state_t            state_dbg
);

  state_t             state_q;
  logic [FCNT_W-1:0]  flush_cnt_q;
  logic [IDX_W-1:0]   idx_q;
  logic [N_PE-1:0]    enable_q;
  logic [N_PE-1:0]    flush_q;
  logic [N_PE-1:0]    s_done_q;
  logic [N_PE-1:0]    r_done_q;
  logic               done_q;
  logic               timed_out_q;
  logic [TO_W-1:0]    run_cycles_q;

  pe_cfg_t cfg_q [N_PE];
  pe_cfg_t cfg_d [N_PE];

  // Config is only writable while idle so a run always sees a stable task set.
  always_comb begin
    for (int i = 0; i < N_PE; i++) cfg_d[i] = cfg_q[i];
    if (cfg_we && (state_q == ST_IDLE)) begin
      cfg_d[cfg_addr] = '{dbg:         cfg_dbg,
                          send_num:    cfg_send_num,
                          receive_num: cfg_receive_num,
                          rate:        cfg_rate,
                          dst_seq:     cfg_dst_seq,
                          mode:        cfg_mode};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_PE; i++) cfg_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_PE; i++) cfg_q[i] <= cfg_d[i];
    end
  end

  logic [N_PE-1:0]        need_s, need_r, active;
  logic [N_PE-1:0]        dbg_flat;
  logic [N_PE*NUM_W-1:0]  send_flat, recv_flat;
  logic [N_PE*RATE_W-1:0] rate_flat;
  logic [N_PE*DST_W-1:0]  dst_flat;
  logic [N_PE*MODE_W-1:0] mode_flat;

  always_comb begin
    need_s    = '0;
    need_r    = '0;
    dbg_flat  = '0;
    send_flat = '0;
    recv_flat = '0;
    rate_flat = '0;
    dst_flat  = '0;
    mode_flat = '0;
    for (int i = 0; i < N_PE; i++) begin
      need_s[i]                      = (cfg_q[i].send_num != '0);
      need_r[i]                      = (cfg_q[i].receive_num != '0);
      dbg_flat[i]                    = cfg_q[i].dbg;
      send_flat[i*NUM_W +: NUM_W]    = cfg_q[i].send_num;
      recv_flat[i*NUM_W +: NUM_W]    = cfg_q[i].receive_num;
      rate_flat[i*RATE_W +: RATE_W]  = cfg_q[i].rate;
      dst_flat[i*DST_W +: DST_W]     = cfg_q[i].dst_seq;
      mode_flat[i*MODE_W +: MODE_W]  = cfg_q[i].mode;
    end
    active = need_s | need_r;
  end

  assign pe.pe_dbg_mode    = dbg_flat;
  assign pe.pe_send_num    = send_flat;
  assign pe.pe_receive_num = recv_flat;
  assign pe.pe_rate        = rate_flat;
  assign pe.pe_dst_seq     = dst_flat;
  assign pe.pe_mode        = mode_flat;
  assign pe.pe_enable      = enable_q;
  assign pe.pe_flush       = flush_q;

  logic complete, timeout_hit;

  // Completion looks only at the registered sticky flags, so a done pulse costs one cycle.
  always_comb begin
    complete    = &((s_done_q | ~need_s) & (r_done_q | ~need_r));
    timeout_hit = (timeout_cycles != '0) && (run_cycles_q == timeout_cycles - TO_W'(1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      flush_cnt_q  <= '0;
      idx_q        <= '0;
      enable_q     <= '0;
      flush_q      <= '0;
      s_done_q     <= '0;
      r_done_q     <= '0;
      done_q       <= 1'b0;
      timed_out_q  <= 1'b0;
      run_cycles_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q      <= ST_FLUSH;
            flush_q      <= '1;
            flush_cnt_q  <= '0;
            run_cycles_q <= '0;
            timed_out_q  <= 1'b0;
            s_done_q     <= '0;
            r_done_q     <= '0;
          end
        end
        ST_FLUSH: begin
          if (flush_cnt_q == FCNT_W'(FLUSH_CYCLES - 1)) begin
            state_q  <= ST_RUN;
            flush_q  <= '0;
            enable_q <= active;
          end else begin
            flush_cnt_q <= flush_cnt_q + FCNT_W'(1);
          end
        end
        ST_RUN: begin
          s_done_q <= s_done_q | pe.pe_send_done;
          r_done_q <= r_done_q | pe.pe_recv_done;
          if (run_cycles_q != '1) run_cycles_q <= run_cycles_q + TO_W'(1);
          if (complete || timeout_hit) begin
            state_q  <= ST_COLLECT;
            enable_q <= '0;
            idx_q    <= '0;
            if (!complete) timed_out_q <= 1'b1;
          end
        end
        ST_COLLECT: begin
          idx_q <= idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(N_PE - 1)) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  logic [LAT_W-1:0] sel_min, sel_max;
  logic [SUM_W-1:0] sel_sum;
  logic             agg_clear, agg_valid;

  always_comb begin
    sel_min = '0;
    sel_max = '0;
    sel_sum = '0;
    for (int i = 0; i < N_PE; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_min = pe.pe_lat_min[i*LAT_W +: LAT_W];
        sel_max = pe.pe_lat_max[i*LAT_W +: LAT_W];
        sel_sum = pe.pe_lat_sum[i*SUM_W +: SUM_W];
      end
    end
    agg_clear = (state_q == ST_IDLE) && start;
    agg_valid = (state_q == ST_COLLECT) && active[idx_q];
  end

  mesh_lat_agg u_agg (
    .clk     (clk),
    .rst     (rst),
    .clear   (agg_clear),
    .valid   (agg_valid),
    .in_min  (sel_min),
    .in_max  (sel_max),
    .in_sum  (sel_sum),
    .agg_min (agg_lat_min),
    .agg_max (agg_lat_max),
    .agg_sum (agg_lat_sum)
  );

  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign timed_out  = timed_out_q;
  assign run_cycles = run_cycles_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_mesh_task_ctrl.sv
// Scenario bench for mesh_task_ctrl: expected run results are queued at start and checked at done.
module tb_mesh_task_ctrl;
  import mesh_task_ctrl_pkg::*;

  localparam int RES_W = 1 + TO_W + 2*LAT_W + SUM_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              cfg_we = 1'b0;
  logic [IDX_W-1:0]  cfg_addr = '0;
  logic              cfg_dbg = 1'b0;
  logic [NUM_W-1:0]  cfg_send_num = '0;
  logic [NUM_W-1:0]  cfg_receive_num = '0;
  logic [RATE_W-1:0] cfg_rate = '0;
  logic [DST_W-1:0]  cfg_dst_seq = '0;
  logic [MODE_W-1:0] cfg_mode = '0;
  logic [TO_W-1:0]   timeout_cycles = '0;
  logic              busy, done, timed_out;
  logic [TO_W-1:0]   run_cycles;
  logic [LAT_W-1:0]  agg_lat_min, agg_lat_max;
  logic [SUM_W-1:0]  agg_lat_sum;
  state_t            state_dbg;

  mesh_task_ctrl_if pe_bus ();

  mesh_task_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_dbg(cfg_dbg), .cfg_send_num(cfg_send_num), .cfg_receive_num(cfg_receive_num),
    .cfg_rate(cfg_rate), .cfg_dst_seq(cfg_dst_seq), .cfg_mode(cfg_mode),
    .timeout_cycles(timeout_cycles), .pe(pe_bus), .busy(busy), .done(done),
    .timed_out(timed_out), .run_cycles(run_cycles), .agg_lat_min(agg_lat_min),
    .agg_lat_max(agg_lat_max), .agg_lat_sum(agg_lat_sum), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  logic [RES_W-1:0] exp_q[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- drivers ----------------
  task automatic cfg_write(input int addr, input logic dbg, input logic [NUM_W-1:0] s,
                           input logic [NUM_W-1:0] r, input logic [RATE_W-1:0] rate);
    cfg_we = 1'b1; cfg_addr = addr[IDX_W-1:0]; cfg_dbg = dbg;
    cfg_send_num = s; cfg_receive_num = r; cfg_rate = rate;
    cfg_dst_seq = rate ^ 8'h5A; cfg_mode = rate[1:0];
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_done(input logic [N_PE-1:0] s, input logic [N_PE-1:0] r);
    pe_bus.pe_send_done = s; pe_bus.pe_recv_done = r;
    @(negedge clk);
    pe_bus.pe_send_done = '0; pe_bus.pe_recv_done = '0;
  endtask

  task automatic set_lat(input int i, input logic [LAT_W-1:0] mn,
                         input logic [LAT_W-1:0] mx, input logic [SUM_W-1:0] sm);
    pe_bus.pe_lat_min[i*LAT_W +: LAT_W] = mn;
    pe_bus.pe_lat_max[i*LAT_W +: LAT_W] = mx;
    pe_bus.pe_lat_sum[i*SUM_W +: SUM_W] = sm;
  endtask

  task automatic wait_state(input state_t s, input int budget, output bit ok);
    int k = 0;
    while (state_dbg !== s && k < budget) begin @(negedge clk); k++; end
    ok = (state_dbg === s);
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int k = 0;
    while (done !== 1'b1 && k < budget) begin @(negedge clk); k++; end
    ok = (done === 1'b1);
  endtask

  function automatic logic [RES_W-1:0] observed();
    return {timed_out, run_cycles, agg_lat_min, agg_lat_max, agg_lat_sum};
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (observed() !== {1'b0, 24'd0, 16'hFFFF, 16'd0, 32'd0}) begin
      tests_failed++; $display("FAIL reset_results: got %h expected %h", observed(),
                               {1'b0, 24'd0, 16'hFFFF, 16'd0, 32'd0});
    end
    tests_run++;
    if ({busy, done, pe_bus.pe_enable, pe_bus.pe_flush} !== 18'd0) begin
      tests_failed++; $display("FAIL reset_ctrl: got busy=%b done=%b en=%h flush=%h expected all 0",
                               busy, done, pe_bus.pe_enable, pe_bus.pe_flush);
    end
    tests_run++;
    if (pe_bus.pe_send_num !== '0 || pe_bus.pe_receive_num !== '0 || state_dbg !== ST_IDLE) begin
      tests_failed++; $display("FAIL reset_cfg: got send=%h recv=%h state=%0d expected 0/0/IDLE",
                               pe_bus.pe_send_num, pe_bus.pe_receive_num, state_dbg);
    end
  endtask

  task automatic test_basic_run();
    int cnt;
    cfg_write(0, 1'b1, 16'd4, 16'd0, 8'h11);
    cfg_write(5, 1'b0, 16'd0, 16'd4, 8'h55);
    tests_run++;
    if (pe_bus.pe_send_num[0 +: 16] !== 16'd4 || pe_bus.pe_receive_num[80 +: 16] !== 16'd4 ||
        pe_bus.pe_rate[0 +: 8] !== 8'h11 || pe_bus.pe_dbg_mode !== 8'h01) begin
      tests_failed++; $display("FAIL cfg_outputs: got s0=%h r5=%h rate0=%h dbg=%h expected 4/4/11/01",
        pe_bus.pe_send_num[0 +: 16], pe_bus.pe_receive_num[80 +: 16], pe_bus.pe_rate[0 +: 8],
        pe_bus.pe_dbg_mode);
    end
    exp_q.push_back({1'b0, 24'd21, 16'd3, 16'd12, 32'd80});
    pulse_start();
    tests_run++;
    if (busy !== 1'b1 || pe_bus.pe_flush !== 8'hFF || pe_bus.pe_enable !== 8'h00) begin
      tests_failed++; $display("FAIL flush_entry: got busy=%b flush=%h en=%h expected 1/ff/00",
                               busy, pe_bus.pe_flush, pe_bus.pe_enable);
    end
    cnt = 0;
    while (pe_bus.pe_flush === 8'hFF && cnt < 20) begin cnt++; @(negedge clk); end
    tests_run++;
    if (cnt !== FLUSH_CYCLES) begin
      tests_failed++; $display("FAIL flush_len: got %0d expected %0d", cnt, FLUSH_CYCLES);
    end
    tests_run++;
    if (state_dbg !== ST_RUN || pe_bus.pe_enable !== 8'h21) begin
      tests_failed++; $display("FAIL run_enable: got state=%0d en=%h expected RUN/21",
                               state_dbg, pe_bus.pe_enable);
    end
    repeat (9) @(negedge clk);
    pulse_done(8'h01, 8'h00);
    repeat (9) @(negedge clk);
    pulse_done(8'h00, 8'h20);
    tests_run++;
    if (state_dbg !== ST_RUN || pe_bus.pe_enable !== 8'h21) begin
      tests_failed++; $display("FAIL run_hold: got state=%0d en=%h expected RUN/21",
                               state_dbg, pe_bus.pe_enable);
    end
    @(negedge clk);
    tests_run++;
    if (state_dbg !== ST_COLLECT || pe_bus.pe_enable !== 8'h00) begin
      tests_failed++; $display("FAIL collect_entry: got state=%0d en=%h expected COLLECT/00",
                               state_dbg, pe_bus.pe_enable);
    end
    cnt = 1;
    while (done !== 1'b1 && cnt < 50) begin @(negedge clk); cnt++; end
    tests_run++;
    if (cnt !== 9) begin
      tests_failed++; $display("FAIL done_latency: got %0d expected 9", cnt);
    end
    tests_run++;
    begin
      logic [RES_W-1:0] e;
      e = exp_q.pop_front();
      if (observed() !== e) begin
        tests_failed++; $display("FAIL basic_result: got %h expected %h", observed(), e);
      end
    end
    @(negedge clk);
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL done_pulse: got done=%b busy=%b expected 0/0", done, busy);
    end
  endtask

  task automatic test_timeout();
    int cnt;
    bit ok;
    logic [RES_W-1:0] e;
    cfg_write(0, 1'b0, 16'd0, 16'd0, 8'h00);
    cfg_write(5, 1'b0, 16'd0, 16'd0, 8'h00);
    cfg_write(2, 1'b0, 16'd0, 16'd4, 8'h22);
    timeout_cycles = 24'd100;
    exp_q.push_back({1'b1, 24'd100, 16'd1, 16'd65535, 32'd999});
    pulse_start();
    wait_state(ST_RUN, 20, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL timeout_reach_run: got state=%0d expected RUN", state_dbg); end
    cnt = 0;
    while (pe_bus.pe_enable === 8'h04 && cnt < 300) begin cnt++; @(negedge clk); end
    tests_run++;
    if (cnt !== 100 || state_dbg !== ST_COLLECT || pe_bus.pe_enable !== 8'h00) begin
      tests_failed++; $display("FAIL timeout_exit: got cycles=%0d state=%0d en=%h expected 100/COLLECT/00",
                               cnt, state_dbg, pe_bus.pe_enable);
    end
    wait_done(40, ok);
    e = exp_q.pop_front();
    tests_run++;
    if (!ok || observed() !== e) begin
      tests_failed++; $display("FAIL timeout_result: got done=%b res=%h expected done=1 res=%h", done, observed(), e);
    end
    repeat (3) @(negedge clk);
    tests_run++;
    if (timed_out !== 1'b1 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL timeout_hold: got timed_out=%b busy=%b expected 1/0", timed_out, busy);
    end
    timeout_cycles = '0;
  endtask

  task automatic test_no_active();
    int cnt, dones;
    logic [RES_W-1:0] got, e;
    cfg_write(2, 1'b0, 16'd0, 16'd0, 8'h00);
    exp_q.push_back({1'b0, 24'd1, 16'hFFFF, 16'd0, 32'd0});
    pulse_start();
    cnt = 0; dones = 0; got = '0;
    while (busy === 1'b1 && cnt < 100) begin
      if (done === 1'b1) begin dones++; got = observed(); end
      cnt++;
      @(negedge clk);
    end
    e = exp_q.pop_front();
    tests_run++;
    if (cnt !== FLUSH_CYCLES + 1 + N_PE + 1 || dones !== 1) begin
      tests_failed++; $display("FAIL idle_run_len: got busy=%0d dones=%0d expected %0d/1",
                               cnt, dones, FLUSH_CYCLES + 1 + N_PE + 1);
    end
    tests_run++;
    if (got !== e) begin
      tests_failed++; $display("FAIL idle_run_result: got %h expected %h", got, e);
    end
  endtask

  task automatic test_blocked_writes();
    int cnt, dones;
    bit ok;
    logic [RES_W-1:0] got, e;
    cfg_write(3, 1'b0, 16'd7, 16'd0, 8'h33);
    exp_q.push_back({1'b0, 24'd3, 16'd1, 16'd65535, 32'd999});
    pulse_start();
    wait_state(ST_RUN, 20, ok);
    cfg_write(3, 1'b1, 16'h1234, 16'h5678, 8'hAA);
    pulse_done(8'h08, 8'h00);
    tests_run++;
    if (!ok || pe_bus.pe_send_num[48 +: 16] !== 16'd7 || pe_bus.pe_receive_num[48 +: 16] !== 16'd0 ||
        pe_bus.pe_rate[24 +: 8] !== 8'h33 || pe_bus.pe_dbg_mode[3] !== 1'b0) begin
      tests_failed++; $display("FAIL run_write_dropped: got ok=%b s3=%h r3=%h rate3=%h dbg3=%b expected 1/0007/0000/33/0",
        ok, pe_bus.pe_send_num[48 +: 16], pe_bus.pe_receive_num[48 +: 16], pe_bus.pe_rate[24 +: 8],
        pe_bus.pe_dbg_mode[3]);
    end
    wait_state(ST_COLLECT, 20, ok);
    pulse_start();
    cnt = 0; dones = 0; got = '0;
    while (cnt < 40) begin
      if (done === 1'b1) begin dones++; got = observed(); end
      cnt++;
      @(negedge clk);
    end
    e = exp_q.pop_front();
    tests_run++;
    if (!ok || dones !== 1 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL collect_start_ignored: got ok=%b dones=%0d busy=%b expected 1/1/0", ok, dones, busy);
    end
    tests_run++;
    if (got !== e) begin
      tests_failed++; $display("FAIL blocked_result: got %h expected %h", got, e);
    end
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    logic [RES_W-1:0] e;
    cfg_write(3, 1'b0, 16'd0, 16'd0, 8'h00);
    cfg_write(1, 1'b0, 16'd5, 16'd0, 8'h01);
    pulse_start();
    wait_state(ST_RUN, 20, ok);
    tests_run++;
    if (!ok || pe_bus.pe_enable !== 8'h02) begin
      tests_failed++; $display("FAIL pre_reset_run: got ok=%b en=%h expected 1/02", ok, pe_bus.pe_enable);
    end
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (pe_bus.pe_enable !== 8'h00 || pe_bus.pe_flush !== 8'h00 || busy !== 1'b0 ||
        pe_bus.pe_send_num !== '0 || pe_bus.pe_rate !== '0) begin
      tests_failed++; $display("FAIL async_reset: got en=%h flush=%h busy=%b send=%h rate=%h expected all 0",
        pe_bus.pe_enable, pe_bus.pe_flush, busy, pe_bus.pe_send_num, pe_bus.pe_rate);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    cfg_write(1, 1'b0, 16'd5, 16'd0, 8'h01);
    exp_q.push_back({1'b0, 24'd2, 16'd1, 16'd65535, 32'd999});
    pulse_start();
    wait_state(ST_RUN, 20, ok);
    pulse_done(8'h02, 8'h00);
    wait_done(40, ok);
    e = exp_q.pop_front();
    tests_run++;
    if (!ok || observed() !== e) begin
      tests_failed++; $display("FAIL post_reset_run: got done=%b res=%h expected done=1 res=%h", done, observed(), e);
    end
  endtask

  task automatic test_sum_saturation();
    bit ok;
    logic [RES_W-1:0] e;
    set_lat(1, 16'd3, 16'd9, 32'hF000_0000);
    set_lat(6, 16'd5, 16'd12, 32'hF000_0000);
    @(negedge clk);
    // Write PE6 in the same cycle as start: the run must include it.
    cfg_we = 1'b1; cfg_addr = 3'd6; cfg_dbg = 1'b0; cfg_send_num = 16'd1;
    cfg_receive_num = 16'd0; cfg_rate = 8'h66; cfg_dst_seq = 8'h01; cfg_mode = 2'd2;
    start = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0; start = 1'b0;
    exp_q.push_back({1'b0, 24'd2, 16'd3, 16'd12, 32'hFFFF_FFFF});
    wait_state(ST_RUN, 20, ok);
    tests_run++;
    if (!ok || pe_bus.pe_enable !== 8'h42) begin
      tests_failed++; $display("FAIL start_with_write: got ok=%b en=%h expected 1/42", ok, pe_bus.pe_enable);
    end
    pulse_done(8'h42, 8'h00);
    wait_done(40, ok);
    e = exp_q.pop_front();
    tests_run++;
    if (!ok || observed() !== e) begin
      tests_failed++; $display("FAIL sum_saturation: got done=%b res=%h expected done=1 res=%h", done, observed(), e);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    pe_bus.pe_send_done = '0;
    pe_bus.pe_recv_done = '0;
    for (int i = 0; i < N_PE; i++) set_lat(i, 16'd1, 16'd65535, 32'd999);
    set_lat(0, 16'd3, 16'd9, 32'd30);
    set_lat(5, 16'd5, 16'd12, 32'd50);
    test_reset();
    test_basic_run();
    test_timeout();
    test_no_active();
    test_blocked_writes();
    test_reset_mid_run();
    test_sum_saturation();
    tests_run++;
    if (exp_q.size() !== 0) begin
      tests_failed++; $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mesh_task_ctrl.md
Name: mesh_task_ctrl

Overview:
Run controller for the 2x4 mesh traffic test: holds per-PE task configuration, flushes the PEs, enables the active ones, waits for their send/receive completion or a timeout, then scans the 8 PEs' latency counters into aggregate min/max/sum. Sits beside the mesh top and drives every PE config/enable/flush input from one host-side write port.

Parameters:
N_PE, 8, number of PEs (index width IDX_W = 3)
NUM_W, 16, width of send_num / receive_num
RATE_W, 8, injection rate field
DST_W, 8, dst_seq field
MODE_W, 2, traffic mode field
LAT_W, 16, per-PE latency_min/max width
SUM_W, 32, per-PE and aggregate latency_sum width
FLUSH_CYCLES, 4, cycles pe_flush is held high
TO_W, 24, run cycle counter / timeout width

Ports:
clk  in  1  clock
rst  in  1  async reset, active-high
start  in  1  begin a run (IDLE only)
cfg_we  in  1  write config for PE cfg_addr
cfg_addr  in  3  PE index
cfg_dbg  in  1  dbg_mode value
cfg_send_num  in  NUM_W  packets to send
cfg_receive_num  in  NUM_W  packets expected
cfg_rate  in  RATE_W  rate value
cfg_dst_seq  in  DST_W  destination sequence
cfg_mode  in  MODE_W  mode value
timeout_cycles  in  TO_W  run timeout limit; 0 = no timeout
pe_enable  out  N_PE  per-PE enable
pe_flush  out  N_PE  per-PE flush
pe_dbg_mode  out  N_PE  per-PE dbg_mode
pe_send_num / pe_receive_num  out  N_PE*NUM_W  flattened, PE i at [i*NUM_W +: NUM_W]
pe_rate / pe_dst_seq / pe_mode  out  N_PE*RATE_W / N_PE*DST_W / N_PE*MODE_W  flattened likewise
pe_send_done / pe_recv_done  in  N_PE  task_send/receive_finish_flag per PE
pe_lat_min / pe_lat_max  in  N_PE*LAT_W  flattened
pe_lat_sum  in  N_PE*SUM_W  flattened
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when the run completes
timed_out  out  1  run ended on timeout; held until next start
run_cycles  out  TO_W  RUN-state cycle count, saturating
agg_lat_min / agg_lat_max  out  LAT_W
agg_lat_sum  out  SUM_W

Behaviour:
- Reset (async): state IDLE; all config registers 0; pe_enable/pe_flush 0; busy/done/timed_out 0; run_cycles 0; agg_lat_min all-ones; agg_lat_max 0; agg_lat_sum 0.
- Config outputs are driven combinationally from the config registers. cfg_we updates PE cfg_addr on the clock edge, but only in IDLE. Writes in any other state are dropped.
- active[i] = (send_num[i]!=0)|(receive_num[i]!=0). need_s[i] = send_num[i]!=0. need_r[i] = receive_num[i]!=0.
- FSM:
  - IDLE: on start, clear run_cycles, timed_out, sticky flags and the aggregates (to their reset values), then go to FLUSH.
  - FLUSH: pe_flush = all ones and pe_enable = 0 for exactly FLUSH_CYCLES cycles, then go to RUN.
  - RUN: pe_enable = active. Sticky s_done[i] |= pe_send_done[i] and r_done[i] |= pe_recv_done[i] each cycle. run_cycles increments, saturating at all-ones.
    - complete = &((s_done|~need_s)&(r_done|~need_r)), evaluated on the registered sticky flags.
    - complete -> COLLECT.
    - Else if timeout_cycles!=0 and run_cycles==timeout_cycles-1 -> set timed_out, go to COLLECT.
    - complete takes priority over timeout in the same cycle.
  - COLLECT: pe_enable = 0. Index runs 0..N_PE-1, one PE per cycle (N_PE cycles). For active PEs only: min = min(min, pe_lat_min[idx]); max = max(max, pe_lat_max[idx]); sum = sum + pe_lat_sum[idx], saturating at 2^SUM_W-1. After the last index, go to DONE.
  - DONE: done = 1 for one cycle, then IDLE. Aggregates, run_cycles and timed_out hold until the next start.
- No active PE: RUN exits after one cycle (run_cycles = 1); aggregates stay at their reset values.
- start is ignored when not in IDLE. start in the same cycle as cfg_we: the write takes effect and the run starts from the new config.
- Latency: start at edge N -> busy at N+1; pe_flush high over N+1..N+FLUSH_CYCLES; RUN begins at N+FLUSH_CYCLES+1.
- Reset mid-run immediately drops pe_enable and pe_flush and loses all configuration.

Decomposition:
- global.v holds the state encoding defines (IDLE, FLUSH, RUN, COLLECT, DONE) and the default widths shared with the PE and top.
- One sub-module, mesh_lat_agg: clear input, valid+index-selected min/max/sum inputs, saturating accumulators, aggregate outputs.

Test Plan:
1. Config PE0 send_num=4 (receive_num=0) and PE5 receive_num=4; start; PE0 send_done at RUN+10, PE5 recv_done at RUN+20 -> pe_enable=8'h21 during RUN, run_cycles=21, timed_out=0, done pulse 8+1 cycles after RUN exit.
2. PE0 and PE5 lat_min/max/sum = 3/9/30 and 5/12/50, inactive PEs drive 1/65535/999 -> agg 3/12/80 (inactive PEs excluded).
3. timeout_cycles=100, PE2 active, recv_done never asserts -> RUN exits at run_cycles=100, timed_out=1, done pulses, pe_enable drops on the exit cycle.
4. All config zero; start -> busy for FLUSH_CYCLES+1+8+1 cycles, agg_lat_min=16'hFFFF, agg_lat_max=0, agg_lat_sum=0.
5. cfg_we to PE3 during RUN and start pulsed during COLLECT -> PE3 config unchanged, no restart, single done pulse.
6. Assert rst during RUN -> pe_enable=0, busy=0 and config=0 in the same cycle (asynchronous); the next start after reconfig runs normally. Separately, pe_lat_sum=32'hF000_0000 on two active PEs -> agg_lat_sum=32'hFFFF_FFFF.
